// File: rtl/sram_pkg.sv
// Shared types and helpers for the wait-state synchronous SRAM.
package sram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Wide enough to hold the largest latency (8).
    localparam int LAT_W = $clog2(9);

    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/sram_array.sv
// Storage array: synchronous write port, combinational read port.
module sram_array #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_sram_wait.sv
// Synchronous SRAM front end with req/ready handshake, fixed wait states
// and out-of-range error reporting.
module sync_sram_wait
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  we_n_q, we_n_d;
    logic                  inr_q, inr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  accept, done, mem_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            inr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            inr_q       <= inr_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
        end
    end

    // A completion and a new accept can share one edge; the accept then
    // overrides the return to IDLE and reloads the counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        we_n_d      = we_n_q;
        inr_d       = inr_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        data_out_d  = data_out_q;
        if (state_q == WAIT) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
        if (done) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            err_d       = !inr_q;
            if (we_n_q) begin
                data_out_d = inr_q ? rd_data : '0;
            end
        end
        if (accept) begin
            state_d = WAIT;
            cnt_d   = LAT_W'(LATENCY);
            idx_d   = addr[IDX_W-1:0];
            wdata_d = data_in;
            we_n_d  = we_n;
            inr_d   = in_range(64'(addr), 64'(DEPTH));
        end
    end

    always_comb begin
        busy      = (state_q == WAIT);
        done      = busy && (cnt_q == LAT_W'(1));
        req_ready = (state_q == IDLE) || done;
        accept    = req && req_ready;
        mem_we    = done && !we_n_q && inr_q;
        rsp_valid = rsp_valid_q;
        err       = err_q;
        data_out  = data_out_q;
    end

    sram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) mem_u (
        .clk  (clk),
        .we   (mem_we),
        .waddr(idx_q),
        .wdata(wdata_q),
        .raddr(idx_q),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_sync_sram_wait.sv
// Directed bench: four instances (LATENCY 1, 3, 2, 4) share one clock.
module tb_sync_sram_wait;

    logic        clk = 1'b0;
    logic        rst_s   [4];
    logic        req_s   [4];
    logic        we_n_s  [4];
    logic [15:0] addr_s  [4];
    logic [15:0] din_s   [4];
    logic        ready_s [4];
    logic        rsp_s   [4];
    logic [15:0] dout_s  [4];
    logic        err_s   [4];
    logic        busy_s  [4];

    int vectors    = 0;
    int miscompares = 0;
    int pulses      = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : gen_dut
        sync_sram_wait #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(16),
            .DEPTH     (1024),
            .LATENCY   (gi == 0 ? 1 : gi == 1 ? 3 : gi == 2 ? 2 : 4)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_s[gi]),
            .req      (req_s[gi]),
            .we_n     (we_n_s[gi]),
            .addr     (addr_s[gi]),
            .data_in  (din_s[gi]),
            .req_ready(ready_s[gi]),
            .rsp_valid(rsp_s[gi]),
            .data_out (dout_s[gi]),
            .err      (err_s[gi]),
            .busy     (busy_s[gi])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        $display("vec %0d %s obs=%b exp=%b", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic r, input logic wn,
                         input logic [15:0] a, input logic [15:0] d);
        req_s[i]  = r;
        we_n_s[i] = wn;
        addr_s[i] = a;
        din_s[i]  = d;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b1;
            drive(i, 1'b0, 1'b1, 16'h0000, 16'h0000);
        end
        gen_dut[0].u_dut.mem_u.mem[100] = 16'h0055;
        gen_dut[0].u_dut.mem_u.mem[0]   = 16'h0BAD;
        gen_dut[0].u_dut.mem_u.mem[976] = 16'h0777;
        gen_dut[1].u_dut.mem_u.mem[200] = 16'h1234;
        gen_dut[3].u_dut.mem_u.mem[5]   = 16'h0000;
        gen_dut[3].u_dut.mem_u.mem[6]   = 16'h0066;
        gen_dut[3].u_dut.mem_u.mem[7]   = 16'h7777;

        // Reset state
        tick();
        tick();
        chk1("rst_ready", ready_s[0], 1'b1);
        chk1("rst_rsp", rsp_s[0], 1'b0);
        chk16("rst_dout", dout_s[0], 16'h0000);
        chk1("rst_busy", busy_s[0], 1'b0);
        chk1("rst_err", err_s[0], 1'b0);
        chk16("rst_mem100", gen_dut[0].u_dut.mem_u.mem[100], 16'h0055);
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;

        // LATENCY=3 read of addr 200
        drive(1, 1'b1, 1'b1, 16'd200, 16'h0000);
        tick();
        chk1("l3_busy_t0", busy_s[1], 1'b1);
        chk1("l3_ready_t0", ready_s[1], 1'b0);
        chk1("l3_rsp_t0", rsp_s[1], 1'b0);
        drive(1, 1'b0, 1'b1, 16'd0, 16'h0000);
        tick();
        chk1("l3_busy_t1", busy_s[1], 1'b1);
        chk1("l3_rsp_t1", rsp_s[1], 1'b0);
        tick();
        chk1("l3_busy_t2", busy_s[1], 1'b1);
        chk1("l3_ready_t2", ready_s[1], 1'b1);
        chk1("l3_rsp_t2", rsp_s[1], 1'b0);
        tick();
        chk1("l3_rsp_t3", rsp_s[1], 1'b1);
        chk16("l3_dout_t3", dout_s[1], 16'h1234);
        chk1("l3_err_t3", err_s[1], 1'b0);
        chk1("l3_busy_t3", busy_s[1], 1'b0);
        tick();
        chk1("l3_rsp_t4", rsp_s[1], 1'b0);
        chk16("l3_dout_hold", dout_s[1], 16'h1234);

        // LATENCY=2 back-to-back write then read of addr 300
        drive(2, 1'b1, 1'b0, 16'd300, 16'h00AB);
        tick();
        chk1("raw_busy_w0", busy_s[2], 1'b1);
        chk1("raw_ready_w0", ready_s[2], 1'b0);
        drive(2, 1'b1, 1'b1, 16'd300, 16'h0000);
        tick();
        chk1("raw_ready_w1", ready_s[2], 1'b1);
        tick();
        chk1("raw_rsp_w", rsp_s[2], 1'b1);
        chk1("raw_err_w", err_s[2], 1'b0);
        chk16("raw_dout_w", dout_s[2], 16'h0000);
        chk1("raw_busy_gap", busy_s[2], 1'b1);
        chk16("raw_mem300", gen_dut[2].u_dut.mem_u.mem[300], 16'h00AB);
        drive(2, 1'b0, 1'b1, 16'd0, 16'h0000);
        tick();
        chk1("raw_rsp_r1", rsp_s[2], 1'b0);
        tick();
        chk1("raw_rsp_r", rsp_s[2], 1'b1);
        chk16("raw_dout_r", dout_s[2], 16'h00AB);

        // LATENCY=1 in-range read, out-of-range write, out-of-range read
        drive(0, 1'b1, 1'b1, 16'd100, 16'h0000);
        tick();
        chk1("oor_ready_1", ready_s[0], 1'b1);
        drive(0, 1'b1, 1'b0, 16'd1024, 16'hFFFF);
        tick();
        chk1("oor_rsp_rd", rsp_s[0], 1'b1);
        chk16("oor_dout_rd", dout_s[0], 16'h0055);
        chk1("oor_err_rd", err_s[0], 1'b0);
        drive(0, 1'b1, 1'b1, 16'd2000, 16'h0000);
        tick();
        chk1("oor_rsp_wr", rsp_s[0], 1'b1);
        chk1("oor_err_wr", err_s[0], 1'b1);
        chk16("oor_dout_wr", dout_s[0], 16'h0055);
        chk16("oor_mem0", gen_dut[0].u_dut.mem_u.mem[0], 16'h0BAD);
        drive(0, 1'b0, 1'b1, 16'd0, 16'h0000);
        tick();
        chk1("oor_rsp_rd2", rsp_s[0], 1'b1);
        chk1("oor_err_rd2", err_s[0], 1'b1);
        chk16("oor_dout_rd2", dout_s[0], 16'h0000);
        tick();
        chk1("oor_rsp_idle", rsp_s[0], 1'b0);
        chk1("oor_err_idle", err_s[0], 1'b0);
        chk1("oor_busy_idle", busy_s[0], 1'b0);

        // LATENCY=4 reset mid-write; simultaneous req loses to reset
        drive(3, 1'b1, 1'b0, 16'd5, 16'h0077);
        tick();
        chk1("rmo_busy_t0", busy_s[3], 1'b1);
        drive(3, 1'b0, 1'b1, 16'd0, 16'h0000);
        tick();
        rst_s[3] = 1'b1;
        drive(3, 1'b1, 1'b0, 16'd5, 16'h0077);
        tick();
        chk1("rmo_busy_rst", busy_s[3], 1'b0);
        chk1("rmo_ready_rst", ready_s[3], 1'b1);
        rst_s[3] = 1'b0;
        drive(3, 1'b0, 1'b1, 16'd0, 16'h0000);
        tick();
        chk1("rmo_busy_after", busy_s[3], 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_s[3]) pulses++;
        end
        chk16("rmo_no_rsp", 16'(pulses), 16'd0);
        chk16("rmo_mem5", gen_dut[3].u_dut.mem_u.mem[5], 16'h0000);

        // LATENCY=4 request while busy is ignored
        drive(3, 1'b1, 1'b1, 16'd6, 16'h0000);
        tick();
        drive(3, 1'b0, 1'b1, 16'd0, 16'h0000);
        pulses = 0;
        tick();
        drive(3, 1'b1, 1'b1, 16'd7, 16'h0000);
        tick();
        chk1("ign_ready_mid", ready_s[3], 1'b0);
        drive(3, 1'b0, 1'b1, 16'd0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_s[3]) pulses++;
        end
        chk16("ign_pulses", 16'(pulses), 16'd1);
        chk16("ign_dout", dout_s[3], 16'h0066);
        chk1("ign_busy_end", busy_s[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
